// File: rtl/program_ram_arbiter.sv
// Shares the single-port program RAM between instruction fetch and the load/store path.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build gives ls fixed priority.
module program_ram_arbiter #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int RAM_LATENCY   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_req,
    input  logic [ADDRESS_WIDTH-1:0] fetch_address,
    output logic                     fetch_ready,
    output logic                     fetch_valid,
    output logic [DATA_WIDTH-1:0]    fetch_data,
    input  logic                     ls_req,
    input  logic                     ls_rw,
    input  logic [ADDRESS_WIDTH-1:0] ls_address,
    input  logic [DATA_WIDTH-1:0]    ls_wdata,
    output logic                     ls_ready,
    output logic                     ls_valid,
    output logic [DATA_WIDTH-1:0]    ls_rdata,
    output logic                     p_ram_en,
    output logic                     p_ram_rw,
    output logic [ADDRESS_WIDTH-1:0] p_ram_address,
    output logic [DATA_WIDTH-1:0]    p_ram_data,
    input  logic [DATA_WIDTH-1:0]    p_ram_q,
    output logic                     busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;
    localparam logic [3:0] LAT_LOAD = 4'(RAM_LATENCY);

    logic [1:0]               state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     win_ls_q, win_ls_d;
    logic                     rw_q, rw_d;
    logic                     fetch_ready_q, fetch_ready_d;
    logic                     fetch_valid_q, fetch_valid_d;
    logic [DATA_WIDTH-1:0]    fetch_data_q, fetch_data_d;
    logic                     ls_ready_q, ls_ready_d;
    logic                     ls_valid_q, ls_valid_d;
    logic [DATA_WIDTH-1:0]    ls_rdata_q, ls_rdata_d;
    logic                     p_ram_en_q, p_ram_en_d;
    logic                     p_ram_rw_q, p_ram_rw_d;
    logic [ADDRESS_WIDTH-1:0] p_ram_address_q, p_ram_address_d;
    logic [DATA_WIDTH-1:0]    p_ram_data_q, p_ram_data_d;
    logic                     busy_q, busy_d;

    logic                     grant_any_s;
    logic                     grant_ls_s;

    assign grant_any_s = fetch_req | ls_req;

`ifdef ARB_ROUND_ROBIN_EN
    // Pointer names the requester preferred on a tie: 0 = fetch, 1 = ls.
    logic rr_ptr_q, rr_ptr_d;

    // Tie-break by pointer and flip the preference away from each winner.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (fetch_req && ls_req) begin
            grant_ls_s = rr_ptr_q;
        end else begin
            grant_ls_s = ls_req;
        end
        if ((state_q == ST_IDLE) && grant_any_s) begin
            rr_ptr_d = ~grant_ls_s;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign grant_ls_s = ls_req;
`endif

    // Next-state and next-output logic; every output is produced one edge ahead.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        win_ls_d        = win_ls_q;
        rw_d            = rw_q;
        fetch_ready_d   = 1'b0;
        fetch_valid_d   = 1'b0;
        fetch_data_d    = fetch_data_q;
        ls_ready_d      = 1'b0;
        ls_valid_d      = 1'b0;
        ls_rdata_d      = ls_rdata_q;
        p_ram_en_d      = 1'b0;
        p_ram_rw_d      = 1'b0;
        p_ram_address_d = p_ram_address_q;
        p_ram_data_d    = p_ram_data_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_any_s) begin
                    state_d       = ST_ISSUE;
                    win_ls_d      = grant_ls_s;
                    rw_d          = grant_ls_s & ls_rw;
                    p_ram_en_d    = 1'b1;
                    p_ram_rw_d    = grant_ls_s & ls_rw;
                    fetch_ready_d = ~grant_ls_s;
                    ls_ready_d    = grant_ls_s;
                    if (grant_ls_s) begin
                        p_ram_address_d = ls_address;
                        p_ram_data_d    = ls_wdata;
                    end else begin
                        p_ram_address_d = fetch_address;
                        p_ram_data_d    = p_ram_data_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = LAT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Count of 1 marks the cycle in which p_ram_q carries valid read data.
                if (cnt_q == 4'd1) begin
                    state_d       = ST_RESP;
                    fetch_valid_d = ~win_ls_q;
                    ls_valid_d    = win_ls_q;
                    if (rw_q) begin
                        ls_rdata_d = ls_rdata_q;
                    end else if (win_ls_q) begin
                        ls_rdata_d = p_ram_q;
                    end else begin
                        fetch_data_d = p_ram_q;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, sequencing and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= 4'd0;
            win_ls_q        <= 1'b0;
            rw_q            <= 1'b0;
            fetch_ready_q   <= 1'b0;
            fetch_valid_q   <= 1'b0;
            fetch_data_q    <= '0;
            ls_ready_q      <= 1'b0;
            ls_valid_q      <= 1'b0;
            ls_rdata_q      <= '0;
            p_ram_en_q      <= 1'b0;
            p_ram_rw_q      <= 1'b0;
            p_ram_address_q <= '0;
            p_ram_data_q    <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            win_ls_q        <= win_ls_d;
            rw_q            <= rw_d;
            fetch_ready_q   <= fetch_ready_d;
            fetch_valid_q   <= fetch_valid_d;
            fetch_data_q    <= fetch_data_d;
            ls_ready_q      <= ls_ready_d;
            ls_valid_q      <= ls_valid_d;
            ls_rdata_q      <= ls_rdata_d;
            p_ram_en_q      <= p_ram_en_d;
            p_ram_rw_q      <= p_ram_rw_d;
            p_ram_address_q <= p_ram_address_d;
            p_ram_data_q    <= p_ram_data_d;
            busy_q          <= busy_d;
        end
    end

    assign fetch_ready   = fetch_ready_q;
    assign fetch_valid   = fetch_valid_q;
    assign fetch_data    = fetch_data_q;
    assign ls_ready      = ls_ready_q;
    assign ls_valid      = ls_valid_q;
    assign ls_rdata      = ls_rdata_q;
    assign p_ram_en      = p_ram_en_q;
    assign p_ram_rw      = p_ram_rw_q;
    assign p_ram_address = p_ram_address_q;
    assign p_ram_data    = p_ram_data_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_program_ram_arbiter.sv
// Scoreboard bench for program_ram_arbiter: three instances (latency 2, 1, 15), each with a latency-exact RAM model.
module tb_program_ram_arbiter;

    localparam int N = 3;

    typedef struct {
        int          inst;
        logic        is_ls;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        fetch_req [N];
    logic [15:0] fetch_address [N];
    logic        fetch_ready [N];
    logic        fetch_valid [N];
    logic [15:0] fetch_data [N];
    logic        ls_req [N];
    logic        ls_rw [N];
    logic [15:0] ls_address [N];
    logic [15:0] ls_wdata [N];
    logic        ls_ready [N];
    logic        ls_valid [N];
    logic [15:0] ls_rdata [N];
    logic        p_ram_en [N];
    logic        p_ram_rw [N];
    logic [15:0] p_ram_address [N];
    logic [15:0] p_ram_data [N];
    logic [15:0] p_ram_q [N];
    logic        busy [N];

    int          lat_of [N] = '{2, 1, 15};
    exp_t        sb_q [$];
    logic [15:0] shadow [N][256];
    logic [15:0] last_ls [N];
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [15:0] pat(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : {a, ~a};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        logic [15:0] mem [256];
        logic [4:0]  age = 5'd0;
        logic [15:0] lat_d = 16'h0000;

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = pat(8'(i));
        end

        // Read data is presented only in the cycle exactly LAT cycles after the enable edge.
        always @(posedge clk) begin
            if (p_ram_en[g]) begin
                age   <= 5'd1;
                lat_d <= mem[p_ram_address[g][7:0]];
                if (p_ram_rw[g]) mem[p_ram_address[g][7:0]] <= p_ram_data[g];
            end else if (age != 5'd0 && age < 5'd20) begin
                age <= age + 5'd1;
            end else begin
                age <= 5'd0;
            end
        end
        assign p_ram_q[g] = (age == 5'(LAT)) ? lat_d : 16'hDEAD;

        program_ram_arbiter #(
            .ADDRESS_WIDTH(16),
            .DATA_WIDTH   (16),
            .RAM_LATENCY  (LAT)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .fetch_req    (fetch_req[g]),
            .fetch_address(fetch_address[g]),
            .fetch_ready  (fetch_ready[g]),
            .fetch_valid  (fetch_valid[g]),
            .fetch_data   (fetch_data[g]),
            .ls_req       (ls_req[g]),
            .ls_rw        (ls_rw[g]),
            .ls_address   (ls_address[g]),
            .ls_wdata     (ls_wdata[g]),
            .ls_ready     (ls_ready[g]),
            .ls_valid     (ls_valid[g]),
            .ls_rdata     (ls_rdata[g]),
            .p_ram_en     (p_ram_en[g]),
            .p_ram_rw     (p_ram_rw[g]),
            .p_ram_address(p_ram_address[g]),
            .p_ram_data   (p_ram_data[g]),
            .p_ram_q      (p_ram_q[g]),
            .busy         (busy[g])
        );
    end

    // Scoreboard: every valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (fetch_valid[i] || ls_valid[i]) begin
                if (sb_q.size() == 0) begin
                    check("sb_nonempty_at_valid", 64'(sb_q.size()), 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_inst", 64'(i), 64'(e.inst));
                    check("resp_kind", 64'(ls_valid[i]), 64'(e.is_ls));
                    check("resp_onehot", 64'(fetch_valid[i] & ls_valid[i]), 64'd0);
                    check("resp_data", 64'(ls_valid[i] ? ls_rdata[i] : fetch_data[i]), 64'(e.data));
                end
            end
        end
    end

    task automatic rst_check(input int idx);
        check("rst_ctrl", 64'({fetch_ready[idx], fetch_valid[idx], ls_ready[idx], ls_valid[idx],
                               p_ram_en[idx], p_ram_rw[idx], busy[idx]}), 64'd0);
        check("rst_data", {fetch_data[idx], ls_rdata[idx], p_ram_address[idx], p_ram_data[idx]}, 64'd0);
    endtask

    task automatic access(input int idx, input logic is_ls, input logic rw,
                          input logic [15:0] addr, input logic [15:0] wdata);
        exp_t e;
        int   ready_k;
        int   valid_k;
        int   en_cnt;
        logic [7:0] a8;
        a8 = addr[7:0];
        @(posedge clk);
        #1;
        if (is_ls) begin
            ls_req[idx] = 1'b1; ls_rw[idx] = rw; ls_address[idx] = addr; ls_wdata[idx] = wdata;
        end else begin
            fetch_req[idx] = 1'b1; fetch_address[idx] = addr;
        end
        e.inst  = idx;
        e.is_ls = is_ls;
        if (is_ls && rw) begin
            shadow[idx][a8] = wdata;
            e.data = last_ls[idx];
        end else begin
            e.data = shadow[idx][a8];
            if (is_ls) last_ls[idx] = e.data;
        end
        sb_q.push_back(e);
        ready_k = -1;
        valid_k = -1;
        en_cnt  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (p_ram_en[idx]) begin
                en_cnt++;
                if (en_cnt == 1) begin
                    check("ram_rw", 64'(p_ram_rw[idx]), 64'(is_ls & rw));
                    check("ram_addr", 64'(p_ram_address[idx]), 64'(addr));
                    if (is_ls && rw) check("ram_wdata", 64'(p_ram_data[idx]), 64'(wdata));
                end
            end
            if (k == 2) check("ram_rw_after_issue", 64'(p_ram_rw[idx]), 64'd0);
            if ((is_ls ? ls_ready[idx] : fetch_ready[idx]) && ready_k < 0) begin
                ready_k = k;
                fetch_req[idx] = 1'b0;
                ls_req[idx] = 1'b0;
            end
            if ((is_ls ? ls_valid[idx] : fetch_valid[idx]) && valid_k < 0) valid_k = k;
            if (valid_k >= 0 && k == valid_k + 1) begin
                check("busy_low_after_resp", 64'(busy[idx]), 64'd0);
                break;
            end
        end
        fetch_req[idx] = 1'b0;
        ls_req[idx] = 1'b0;
        check("ready_cycle", 64'(ready_k), 64'd1);
        check("valid_cycle", 64'(valid_k), 64'(2 + lat_of[idx]));
        check("ready_to_valid", 64'(valid_k - ready_k), 64'(lat_of[idx] + 1));
        check("en_count", 64'(en_cnt), 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   got;
        int   wait_k;
        logic winner;
        logic exp_w;
        logic fetch_seen;
        int   valid_seen;
        exp_t e;

        for (int i = 0; i < N; i++) begin
            fetch_req[i] = 1'b0; fetch_address[i] = 16'h0000;
            ls_req[i] = 1'b0; ls_rw[i] = 1'b0; ls_address[i] = 16'h0000; ls_wdata[i] = 16'h0000;
            last_ls[i] = 16'h0000;
            for (int a = 0; a < 256; a++) shadow[i][a] = pat(8'(a));
        end

        // Reset with both requests high: outputs stay cleared.
        reset = 1'b1;
        fetch_req[0] = 1'b1; ls_req[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst_check(0);
        fetch_req[0] = 1'b0; ls_req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        access(0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        access(0, 1'b1, 1'b1, 16'h0200, 16'h1234);
        access(0, 1'b1, 1'b0, 16'h0200, 16'h0000);
        access(0, 1'b0, 1'b0, 16'h00A5, 16'h0000);

        // Contention: both requesters held across four grants, starting from a fresh pointer.
        @(negedge clk);
        reset = 1'b1;
        last_ls[0] = 16'h0000;
        fetch_req[0] = 1'b1; fetch_address[0] = 16'h0040;
        ls_req[0] = 1'b1; ls_rw[0] = 1'b0; ls_address[0] = 16'h0030;
        @(negedge clk);
        reset = 1'b0;
        fetch_seen = 1'b0;
        for (int n = 0; n < 4; n++) begin
            got = -1;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (fetch_ready[0] || ls_ready[0]) begin
                    got = k;
                    break;
                end
            end
            check("grant_seen", 64'(got >= 0), 64'd1);
            winner = ls_ready[0];
            fetch_seen = fetch_seen | fetch_ready[0];
`ifdef ARB_ROUND_ROBIN_EN
            exp_w = (n % 2 == 1);
`else
            exp_w = 1'b1;
`endif
            check("arb_winner", 64'(winner), 64'(exp_w));
            e.inst  = 0;
            e.is_ls = exp_w;
            e.data  = exp_w ? shadow[0][8'h30] : shadow[0][8'h40];
            if (exp_w) last_ls[0] = e.data;
            sb_q.push_back(e);
            if (n == 3) begin
                fetch_req[0] = 1'b0;
                ls_req[0] = 1'b0;
            end
        end
`ifndef ARB_ROUND_ROBIN_EN
        check("fetch_starved", 64'(fetch_seen), 64'd0);
`endif
        repeat (8) @(negedge clk);

        // Reset during WAIT of a load aborts it without a valid.
        @(posedge clk);
        #1;
        ls_req[0] = 1'b1; ls_rw[0] = 1'b0; ls_address[0] = 16'h0055;
        wait_k = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ls_ready[0]) begin
                wait_k = k;
                break;
            end
        end
        check("abort_ready_seen", 64'(wait_k), 64'd1);
        ls_req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        rst_check(0);
        valid_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ls_valid[0]) valid_seen++;
        end
        check("abort_no_valid", 64'(valid_seen), 64'd0);
        rst_check(0);
        last_ls[0] = 16'h0000;
        reset = 1'b0;
        access(0, 1'b1, 1'b0, 16'h0055, 16'h0000);

        // Latency sweep on the latency-1 and latency-15 instances.
        access(1, 1'b0, 1'b0, 16'h0011, 16'h0000);
        access(1, 1'b1, 1'b1, 16'h0022, 16'hC0DE);
        access(1, 1'b1, 1'b0, 16'h0022, 16'h0000);
        access(2, 1'b0, 1'b0, 16'h0033, 16'h0000);
        access(2, 1'b1, 1'b1, 16'h0044, 16'h7777);
        access(2, 1'b1, 1'b0, 16'h0044, 16'h0000);

        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
